// File: rtl/rvh_tlb_flush_ctrl_pkg.sv
// Shared MMU definitions: address widths, TLB flush payload and flush FSM encoding.
package rvh_tlb_flush_ctrl_pkg;

  localparam int unsigned VPN_WIDTH  = 27;
  localparam int unsigned ASID_WIDTH = 16;

  // Flush payload broadcast to both DTLB and ITLB
  typedef struct packed {
    logic                  use_asid;
    logic                  use_vpn;
    logic [VPN_WIDTH-1:0]  vpn;
    logic [ASID_WIDTH-1:0] asid;
  } tlb_flush_req_t;

  typedef logic [1:0] flush_state_t;

  localparam flush_state_t ST_IDLE  = 2'd0;
  localparam flush_state_t ST_DRAIN = 2'd1;
  localparam flush_state_t ST_FLUSH = 2'd2;
  localparam flush_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/rvh_tlb_flush_ctrl.sv
// SFENCE.VMA flush sequencer: blocks PTW misses, drains in-flight walks,
// flushes DTLB and ITLB over independent handshakes, then pulses completion.
module rvh_tlb_flush_ctrl
  import rvh_tlb_flush_ctrl_pkg::*;
#(
  parameter int unsigned OUTST_CNT_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush_req_vld_i,
  input  logic                  flush_req_use_asid_i,
  input  logic                  flush_req_use_vpn_i,
  input  logic [VPN_WIDTH-1:0]  flush_req_vpn_i,
  input  logic [ASID_WIDTH-1:0] flush_req_asid_i,
  output logic                  flush_req_rdy_o,
  output logic                  flush_done_o,
  output logic                  busy_o,
  input  logic                  miss_req_fire_i,
  input  logic                  miss_resp_fire_i,
  output logic                  miss_req_block_o,
  output logic                  flush_use_asid_o,
  output logic                  flush_use_vpn_o,
  output logic [VPN_WIDTH-1:0]  flush_vpn_o,
  output logic [ASID_WIDTH-1:0] flush_asid_o,
  output logic                  dtlb_flush_vld_o,
  input  logic                  dtlb_flush_rdy_i,
  output logic                  itlb_flush_vld_o,
  input  logic                  itlb_flush_rdy_i
);

  localparam logic [OUTST_CNT_WIDTH-1:0] CNT_MAX = '1;

  flush_state_t                state_q, state_d;
  logic [OUTST_CNT_WIDTH-1:0]  outst_cnt_q, outst_cnt_d;
  logic                        dtlb_done_q, dtlb_done_d;
  logic                        itlb_done_q, itlb_done_d;
  tlb_flush_req_t              payload_q, payload_d;

  // Saturating count of PTW walks in flight; runs regardless of FSM state
  always_comb begin
    outst_cnt_d = outst_cnt_q;
    if (miss_req_fire_i && !miss_resp_fire_i && (outst_cnt_q != CNT_MAX)) begin
      outst_cnt_d = outst_cnt_q + OUTST_CNT_WIDTH'(1);
    end else if (!miss_req_fire_i && miss_resp_fire_i && (outst_cnt_q != '0)) begin
      outst_cnt_d = outst_cnt_q - OUTST_CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    payload_d   = payload_q;
    dtlb_done_d = dtlb_done_q;
    itlb_done_d = itlb_done_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_req_vld_i) begin
          payload_d   = '{use_asid: flush_req_use_asid_i,
                          use_vpn:  flush_req_use_vpn_i,
                          vpn:      flush_req_vpn_i,
                          asid:     flush_req_asid_i};
          dtlb_done_d = 1'b0;
          itlb_done_d = 1'b0;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (outst_cnt_q == '0) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // A TLB is complete once its done bit is set or it handshakes now
        dtlb_done_d = dtlb_done_q | dtlb_flush_rdy_i;
        itlb_done_d = itlb_done_q | itlb_flush_rdy_i;
        if (dtlb_done_d && itlb_done_d) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q     <= ST_IDLE;
      outst_cnt_q <= '0;
      dtlb_done_q <= 1'b0;
      itlb_done_q <= 1'b0;
      payload_q   <= '0;
    end else begin
      state_q     <= state_d;
      outst_cnt_q <= outst_cnt_d;
      dtlb_done_q <= dtlb_done_d;
      itlb_done_q <= itlb_done_d;
      payload_q   <= payload_d;
    end
  end

  // Outputs decode registered state only; no input-to-output paths
  always_comb begin
    flush_req_rdy_o  = (state_q == ST_IDLE);
    busy_o           = (state_q != ST_IDLE);
    miss_req_block_o = (state_q != ST_IDLE);
    flush_done_o     = (state_q == ST_DONE);
    dtlb_flush_vld_o = (state_q == ST_FLUSH) && !dtlb_done_q;
    itlb_flush_vld_o = (state_q == ST_FLUSH) && !itlb_done_q;
    flush_use_asid_o = payload_q.use_asid;
    flush_use_vpn_o  = payload_q.use_vpn;
    flush_vpn_o      = payload_q.vpn;
    flush_asid_o     = payload_q.asid;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rstn)
    !(miss_req_fire_i && !miss_resp_fire_i && (outst_cnt_q == CNT_MAX)));

  a_no_underflow: assert property (@(posedge clk) disable iff (rstn)
    !(!miss_req_fire_i && miss_resp_fire_i && (outst_cnt_q == '0)));

endmodule

// File: tb/tb_rvh_tlb_flush_ctrl.sv
// Self-checking bench for rvh_tlb_flush_ctrl: transaction-level reference model
// compared every cycle, directed scenarios with literal expectations, random traffic.
module tb_rvh_tlb_flush_ctrl;
  import rvh_tlb_flush_ctrl_pkg::*;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b1;
  logic                  flush_req_vld_i = 1'b0;
  logic                  flush_req_use_asid_i = 1'b0;
  logic                  flush_req_use_vpn_i = 1'b0;
  logic [VPN_WIDTH-1:0]  flush_req_vpn_i = '0;
  logic [ASID_WIDTH-1:0] flush_req_asid_i = '0;
  logic                  flush_req_rdy_o, flush_done_o, busy_o, miss_req_block_o;
  logic                  miss_req_fire_i = 1'b0;
  logic                  miss_resp_fire_i = 1'b0;
  logic                  flush_use_asid_o, flush_use_vpn_o;
  logic [VPN_WIDTH-1:0]  flush_vpn_o;
  logic [ASID_WIDTH-1:0] flush_asid_o;
  logic                  dtlb_flush_vld_o, itlb_flush_vld_o;
  logic                  dtlb_flush_rdy_i = 1'b0;
  logic                  itlb_flush_rdy_i = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  rvh_tlb_flush_ctrl #(.OUTST_CNT_WIDTH(2)) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .flush_req_vld_i      (flush_req_vld_i),
    .flush_req_use_asid_i (flush_req_use_asid_i),
    .flush_req_use_vpn_i  (flush_req_use_vpn_i),
    .flush_req_vpn_i      (flush_req_vpn_i),
    .flush_req_asid_i     (flush_req_asid_i),
    .flush_req_rdy_o      (flush_req_rdy_o),
    .flush_done_o         (flush_done_o),
    .busy_o               (busy_o),
    .miss_req_fire_i      (miss_req_fire_i),
    .miss_resp_fire_i     (miss_resp_fire_i),
    .miss_req_block_o     (miss_req_block_o),
    .flush_use_asid_o     (flush_use_asid_o),
    .flush_use_vpn_o      (flush_use_vpn_o),
    .flush_vpn_o          (flush_vpn_o),
    .flush_asid_o         (flush_asid_o),
    .dtlb_flush_vld_o     (dtlb_flush_vld_o),
    .dtlb_flush_rdy_i     (dtlb_flush_rdy_i),
    .itlb_flush_vld_o     (itlb_flush_vld_o),
    .itlb_flush_rdy_i     (itlb_flush_rdy_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a flush is a transaction that waits for zero walks,
  // collects one acknowledgement from each TLB, then reports completion once.
  int            m_walks = 0;
  bit            m_active = 1'b0;
  bit            m_waiting = 1'b0;
  bit            m_d_pend = 1'b0;
  bit            m_i_pend = 1'b0;
  bit            m_report = 1'b0;
  logic [63:0]   m_payload = '0;

  always @(negedge clk) begin
    int  walks_n;
    bit  active_n, waiting_n, d_pend_n, i_pend_n, report_n;
    bit  acking;
    logic [63:0] payload_n;
    if (chk_en) begin
      acking = m_active && !m_waiting && !m_report;
      chk("rdy",   64'(flush_req_rdy_o),  64'(!m_active));
      chk("busy",  64'(busy_o),           64'(m_active));
      chk("block", 64'(miss_req_block_o), 64'(m_active));
      chk("done",  64'(flush_done_o),     64'(m_report));
      chk("dvld",  64'(dtlb_flush_vld_o), 64'(acking && m_d_pend));
      chk("ivld",  64'(itlb_flush_vld_o), 64'(acking && m_i_pend));
      chk("payload", 64'({flush_use_asid_o, flush_use_vpn_o, flush_vpn_o, flush_asid_o}), m_payload);
    end
    walks_n   = m_walks + int'(miss_req_fire_i) - int'(miss_resp_fire_i);
    walks_n   = (walks_n < 0) ? 0 : ((walks_n > 3) ? 3 : walks_n);
    active_n  = m_active;
    waiting_n = m_waiting;
    d_pend_n  = m_d_pend;
    i_pend_n  = m_i_pend;
    report_n  = m_report;
    payload_n = m_payload;
    if (!m_active) begin
      if (flush_req_vld_i) begin
        active_n  = 1'b1;
        waiting_n = 1'b1;
        d_pend_n  = 1'b1;
        i_pend_n  = 1'b1;
        payload_n = 64'({flush_req_use_asid_i, flush_req_use_vpn_i, flush_req_vpn_i, flush_req_asid_i});
      end
    end else if (m_report) begin
      active_n = 1'b0;
      report_n = 1'b0;
    end else if (m_waiting) begin
      if (m_walks == 0) waiting_n = 1'b0;
    end else begin
      if (dtlb_flush_rdy_i) d_pend_n = 1'b0;
      if (itlb_flush_rdy_i) i_pend_n = 1'b0;
      if (!d_pend_n && !i_pend_n) report_n = 1'b1;
    end
    if (rstn) begin
      walks_n = 0; active_n = 1'b0; waiting_n = 1'b0; d_pend_n = 1'b0;
      i_pend_n = 1'b0; report_n = 1'b0; payload_n = '0;
    end
    m_walks = walks_n; m_active = active_n; m_waiting = waiting_n;
    m_d_pend = d_pend_n; m_i_pend = i_pend_n; m_report = report_n; m_payload = payload_n;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_flush(input logic [VPN_WIDTH-1:0] vpn, input logic [ASID_WIDTH-1:0] asid);
    flush_req_vld_i      = 1'b1;
    flush_req_use_asid_i = 1'b1;
    flush_req_use_vpn_i  = 1'b1;
    flush_req_vpn_i      = vpn;
    flush_req_asid_i     = asid;
  endtask

  initial begin
    int  s_cnt;
    bit  rdy_prev;
    step();
    rstn = 1'b0;
    chk_en = 1'b1;
    chk("lit_reset_rdy",  64'(flush_req_rdy_o), 64'd1);
    chk("lit_reset_busy", 64'(busy_o), 64'd0);
    chk("lit_reset_vpn",  64'(flush_vpn_o), 64'd0);

    // Minimum-latency flush with both TLBs ready
    dtlb_flush_rdy_i = 1'b1;
    itlb_flush_rdy_i = 1'b1;
    send_flush(27'h1234, 16'h5);
    step(); flush_req_vld_i = 1'b0;
    chk("lit_t1_c1_busy", 64'(busy_o), 64'd1);
    chk("lit_t1_c1_dvld", 64'(dtlb_flush_vld_o), 64'd0);
    step();
    chk("lit_t1_c2_dvld", 64'(dtlb_flush_vld_o), 64'd1);
    chk("lit_t1_c2_ivld", 64'(itlb_flush_vld_o), 64'd1);
    step();
    chk("lit_t1_c3_done", 64'(flush_done_o), 64'd1);
    step();
    chk("lit_t1_c4_rdy",  64'(flush_req_rdy_o), 64'd1);
    chk("lit_t1_c4_done", 64'(flush_done_o), 64'd0);
    chk("lit_t1_vpn",     64'(flush_vpn_o), 64'h1234);
    chk("lit_t1_asid",    64'(flush_asid_o), 64'h5);

    // Two walks in flight, responses at accept+5 and accept+9
    miss_req_fire_i = 1'b1;
    step();
    step(); miss_req_fire_i = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) step();
      flush_req_vld_i  = (k == 0);
      miss_resp_fire_i = (k == 5) || (k == 9);
      if (k > 0) begin
        chk("lit_t2_block", 64'(miss_req_block_o), 64'd1);
        chk("lit_t2_dvld",  64'(dtlb_flush_vld_o), 64'(k == 11));
      end
    end
    miss_resp_fire_i = 1'b0;
    step();

    // Staggered TLB acknowledgements
    dtlb_flush_rdy_i = 1'b0;
    itlb_flush_rdy_i = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) step();
      flush_req_vld_i  = (k == 0);
      dtlb_flush_rdy_i = (k == 2);
      itlb_flush_rdy_i = (k == 5);
      if (k > 0) begin
        chk("lit_t3_dvld", 64'(dtlb_flush_vld_o), 64'(k == 2));
        chk("lit_t3_ivld", 64'(itlb_flush_vld_o), 64'((k >= 2) && (k <= 5)));
        chk("lit_t3_done", 64'(flush_done_o), 64'(k == 6));
      end
    end

    // Miss fire coincident with acceptance, plus req/resp overlap at count 1
    dtlb_flush_rdy_i = 1'b1;
    itlb_flush_rdy_i = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        miss_req_fire_i = 1'b1;
        step();
      end
      for (int k = 0; k <= 7; k++) begin
        if (k > 0) step();
        flush_req_vld_i  = (k == 0);
        miss_req_fire_i  = (k == 0);
        miss_resp_fire_i = (k == 3) || ((pass == 1) && (k == 0));
        if (k > 0) chk("lit_t4_dvld", 64'(dtlb_flush_vld_o), 64'(k == 5));
      end
    end
    miss_req_fire_i  = 1'b0;
    miss_resp_fire_i = 1'b0;

    // Reset while in FLUSH aborts without a completion pulse
    dtlb_flush_rdy_i = 1'b0;
    itlb_flush_rdy_i = 1'b0;
    send_flush(27'h7ffffff, 16'hbeef);
    for (int k = 1; k <= 7; k++) begin
      step();
      flush_req_vld_i = 1'b0;
      rstn = (k == 3);
      if (k == 3) chk("lit_t6_dvld_pre", 64'(dtlb_flush_vld_o), 64'd1);
      if (k >= 4) begin
        chk("lit_t6_dvld", 64'(dtlb_flush_vld_o), 64'd0);
        chk("lit_t6_ivld", 64'(itlb_flush_vld_o), 64'd0);
        chk("lit_t6_done", 64'(flush_done_o), 64'd0);
        chk("lit_t6_rdy",  64'(flush_req_rdy_o), 64'd1);
      end
    end
    dtlb_flush_rdy_i = 1'b1;
    itlb_flush_rdy_i = 1'b1;
    send_flush(27'h55, 16'h1);
    step(); flush_req_vld_i = 1'b0;
    step(); step();
    chk("lit_t6_redo_done", 64'(flush_done_o), 64'd1);
    step();

    // Random traffic with legal walk counts and held flush requests
    s_cnt = 0;
    rdy_prev = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (flush_req_vld_i && rdy_prev) flush_req_vld_i = 1'b0;
      if (!flush_req_vld_i && ($urandom_range(0, 7) == 0)) begin
        flush_req_vld_i      = 1'b1;
        flush_req_use_asid_i = 1'($urandom);
        flush_req_use_vpn_i  = 1'($urandom);
        flush_req_vpn_i      = VPN_WIDTH'($urandom);
        flush_req_asid_i     = ASID_WIDTH'($urandom);
      end
      miss_req_fire_i  = ($urandom_range(0, 3) == 0);
      miss_resp_fire_i = ($urandom_range(0, 3) == 0) && (s_cnt > 0);
      if (miss_req_fire_i && !miss_resp_fire_i && (s_cnt == 3)) miss_req_fire_i = 1'b0;
      dtlb_flush_rdy_i = 1'($urandom);
      itlb_flush_rdy_i = 1'($urandom);
      rstn = ($urandom_range(0, 249) == 0);
      if (rstn) s_cnt = 0;
      else s_cnt = s_cnt + int'(miss_req_fire_i) - int'(miss_resp_fire_i);
      rdy_prev = flush_req_rdy_o && !rstn;
    end
    rstn = 1'b0;
    step();
    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rvh_tlb_flush_ctrl.md
Name: rvh_tlb_flush_ctrl

Overview:
Sequences SFENCE.VMA-style TLB flushes for the MMU complex.
- Accepts one flush request at a time.
- Blocks new TLB miss requests toward the PTW and drains walks already in flight.
- Issues the flush to DTLB and ITLB through independent valid/ready handshakes, then pulses completion. The completion pulse replaces the hard-tied tlb_flush_grant.
- Sits beside the MMU miss arbiter. It observes translate request/response handshakes and gates the arbiter's ready.

Parameters:
- VPN_WIDTH, 27, virtual page number width (Sv39).
- ASID_WIDTH, 16, address-space ID width.
- OUTST_CNT_WIDTH, 2, width of the outstanding-walk counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous reset, active-high (rstn=1 resets on the clk rising edge).
- flush_req_vld_i  in  1  flush request valid.
- flush_req_use_asid_i  in  1  flush is ASID-qualified.
- flush_req_use_vpn_i  in  1  flush is VPN-qualified.
- flush_req_vpn_i  in  VPN_WIDTH  flush VPN.
- flush_req_asid_i  in  ASID_WIDTH  flush ASID.
- flush_req_rdy_o  out  1  request accepted this cycle.
- flush_done_o  out  1  one-cycle completion pulse.
- busy_o  out  1  controller not idle.
- miss_req_fire_i  in  1  translate request handshake (vld&rdy) at the PTW.
- miss_resp_fire_i  in  1  translate response handshake at the PTW.
- miss_req_block_o  out  1  arbiter must force miss ready low.
- flush_use_asid_o  out  1  latched payload, shared by both TLBs.
- flush_use_vpn_o  out  1  latched payload, shared by both TLBs.
- flush_vpn_o  out  VPN_WIDTH  latched payload, shared by both TLBs.
- flush_asid_o  out  ASID_WIDTH  latched payload, shared by both TLBs.
- dtlb_flush_vld_o  out  1  DTLB flush valid.
- dtlb_flush_rdy_i  in  1  DTLB accepted the flush.
- itlb_flush_vld_o  out  1  ITLB flush valid.
- itlb_flush_rdy_i  in  1  ITLB accepted the flush.

Behaviour:
- Reset:
  - State is IDLE, the outstanding counter is 0, and both done bits are 0.
  - All outputs are 0 except flush_req_rdy_o=1.
  - The payload registers reset to 0.
- Outstanding counter:
  - Increments on miss_req_fire_i and decrements on miss_resp_fire_i. Both in the same cycle leaves it unchanged.
  - Saturates at 2^OUTST_CNT_WIDTH-1 and holds at 0 on underflow.
  - Overflow and underflow are assertion failures in simulation.
  - The counter runs in every state.
- FSM states are IDLE, DRAIN, FLUSH and DONE.
- IDLE:
  - flush_req_rdy_o=1.
  - On flush_req_vld_i, latch the payload, clear both done bits, and go to DRAIN.
- DRAIN:
  - Wait until the registered counter is 0, then go to FLUSH.
  - A miss fire in the same cycle as flush acceptance is counted and must be drained.
- FLUSH:
  - dtlb_flush_vld_o = ~dtlb_done_q and itlb_flush_vld_o = ~itlb_done_q.
  - A done bit sets on its handshake. A valid, once raised, stays high until its handshake.
  - When both TLBs are complete (registered bit or handshake this cycle, simultaneous allowed), go to DONE.
- DONE:
  - flush_done_o=1 for exactly one cycle, then return to IDLE.
- Static outputs:
  - miss_req_block_o = busy_o = (state != IDLE). These are decoded from the state register only, with no combinational path from inputs.
  - Payload outputs stay stable from acceptance until return to IDLE and are not cleared on DONE.
- Minimum latency:
  - Accept at cycle 0, DRAIN at 1, FLUSH at 2 with both ready, flush_done_o at 3, next acceptance at 4.
- Reset mid-operation aborts the flush with no done pulse. All valids drop the cycle after reset is sampled.
- flush_req_vld_i while busy is ignored. The requester holds it until flush_req_rdy_o.

Decomposition:
- Shared MMU package holds:
  - VPN_WIDTH, ASID_WIDTH and the TLB flush payload struct {use_asid, use_vpn, vpn, asid}, reused by both TLBs.
  - The FSM state enum.
- No sub-module; the saturating up/down counter is inline.

Test Plan:
1. Idle flush, counter 0, both ready tied 1 → dtlb and itlb vld high in cycle 2, flush_done_o in cycle 3, flush_req_rdy_o back in cycle 4, payload echoed (vpn=0x1234, asid=0x5).
2. Two miss fires, then flush, then responses at +5 and +9 → FLUSH entered only after the second response, miss_req_block_o high throughout.
3. DTLB ready at FLUSH+0 and ITLB ready at FLUSH+3 → dtlb_flush_vld_o drops after 1 cycle, itlb_flush_vld_o held 4 cycles, single done pulse.
4. miss_req_fire_i and flush_req_vld_i in the same cycle → DRAIN waits for the matching miss_resp_fire_i.
5. Simultaneous req/resp fire with count 1 → count stays 1; resp with count 0 → count stays 0 and the assertion fires.
6. rstn pulse during FLUSH → the next cycle is IDLE, valids are 0, there is no flush_done_o, and a new flush completes normally.
